// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : redirect/freeze state encoding
//   REG_W      : default register-index width
//   X0         : index of the hard-wired zero register
package core_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FREEZE      = 2'd1,
    FREEZE_PEND = 2'd2
  } hz_state_t;

  localparam int REG_W = 5;
  localparam int X0    = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : count up by one (ignored once at MAX)
//   i_clear    : synchronous clear, wins over i_inc
//   o_count    : current count
//   o_sat      : count equals MAX
module sat_counter
  import core_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sat
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == MAX);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes and
// whole-pipe freeze during multi-cycle data-memory accesses. A redirect that
// arrives while memory is busy is remembered and issued on release.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   idex_mem_read, idex_rd      : load flag / destination of the EX instruction
//   ifid_rs1/rs2, ifid_uses_*   : source registers of the ID instruction
//   ex_branch_taken             : one-cycle redirect pulse from EX
//   dmem_busy                   : data memory not ready
//   stall, id_flush             : ID/EX bubble qualifiers
//   if_flush                    : clear IF/ID
//   pc_write, ifid_write        : PC and IF/ID enables
//   pipe_freeze                 : hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                 : sticky busy-too-long error
//   stall_count                 : saturating count of stalled cycles
//
// State table:
//   RUN         | no freeze in progress
//   FREEZE      | memory busy, no redirect owed
//   FREEZE_PEND | memory busy, redirect owed on release
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_W       = core_pkg::REG_W,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             stall,
  output logic             id_flush,
  output logic             if_flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                BUSY_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(TIMEOUT_CYC);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT_CYC - 1);

  hz_state_t         r_st;
  hz_state_t         w_st_nxt;
  logic              r_mem_timeout;
  logic              w_lu;
  logic              w_redirect;
  logic [BUSY_W-1:0] w_busy_cnt;
  logic              w_busy_sat;
  logic              w_stall_sat;

  assign w_lu = idex_mem_read && (idex_rd != REG_W'(X0)) &&
                ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                 (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  // A fresh branch in the release cycle of FREEZE_PEND folds into the same redirect.
  assign w_redirect = ex_branch_taken || (r_st == FREEZE_PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= RUN;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = RUN;
    stall       = 1'b0;
    id_flush    = 1'b0;
    if_flush    = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    pipe_freeze = 1'b0;

    case (r_st)
      RUN, FREEZE: begin
        if (dmem_busy && ex_branch_taken) w_st_nxt = FREEZE_PEND;
        else if (dmem_busy)               w_st_nxt = FREEZE;
        else                              w_st_nxt = RUN;
      end
      FREEZE_PEND: w_st_nxt = dmem_busy ? FREEZE_PEND : RUN;
      default:     w_st_nxt = RUN;
    endcase

    if (rst_n) begin
      if (dmem_busy) begin
        pipe_freeze = 1'b1;
        stall       = 1'b1;
      end else if (w_redirect) begin
        // ID holds a wrong-path instruction, so any load-use match is moot.
        if_flush   = 1'b1;
        id_flush   = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end else if (w_lu) begin
        stall = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (BUSY_W),
    .MAX   (BUSY_MAX)
  ) u_busy_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (dmem_busy),
    .i_clear (!dmem_busy),
    .o_count (w_busy_cnt),
    .o_sat   (w_busy_sat)
  );

  // Set on the edge that completes TIMEOUT_CYC consecutive busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (dmem_busy && ((w_busy_cnt == BUSY_LAST) || w_busy_sat)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (stall && !w_stall_sat),
    .i_clear (1'b0),
    .o_count (stall_count),
    .o_sat   (w_stall_sat)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int REG_W       = 5;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 4;

  // {stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze}
  localparam logic [5:0] ZERO  = 6'b000000;
  localparam logic [5:0] NORM  = 6'b000110;
  localparam logic [5:0] FRZ   = 6'b100001;
  localparam logic [5:0] REDIR = 6'b011110;
  localparam logic [5:0] LUS   = 6'b100000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_uses_rs1;
  logic             ifid_uses_rs2;
  logic             ex_branch_taken;
  logic             dmem_busy;
  logic             stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [5:0]       ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  assign ctl = {stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze};

  hazard_ctrl #(
    .REG_W       (REG_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .idex_mem_read   (idex_mem_read),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_uses_rs1   (ifid_uses_rs1),
    .ifid_uses_rs2   (ifid_uses_rs2),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .stall           (stall),
    .id_flush        (id_flush),
    .if_flush        (if_flush),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .pipe_freeze     (pipe_freeze),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; ex_branch_taken = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0; dmem_busy = 1;
    #2;
    n_cmp++; if (ctl !== ZERO) begin $display("FAIL reset_ctl got=%b exp=%b", ctl, ZERO); n_fail++; end
    n_cmp++; if (mem_timeout !== 1'b0) begin $display("FAIL reset_timeout got=%b exp=0", mem_timeout); n_fail++; end
    n_cmp++; if (stall_count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", stall_count); n_fail++; end
    tick(); tick();
    dmem_busy = 0; rst_n = 1;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL post_reset_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
  endtask

  task automatic test_load_use();
    tick();
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 3; ifid_rs2 = 5;
    ifid_uses_rs1 = 1; ifid_uses_rs2 = 1;
    #1;
    n_cmp++; if (ctl !== LUS) begin $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, LUS); n_fail++; end
    tick();
    idex_mem_read = 0;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL lu_after_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    n_cmp++; if (stall_count !== 4'd1) begin $display("FAIL lu_count1 got=%0d exp=1", stall_count); n_fail++; end
    idex_mem_read = 1; idex_rd = 3;
    #1;
    n_cmp++; if (ctl !== LUS) begin $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl, LUS); n_fail++; end
    tick();
    idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL lu_x0_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    idex_rd = 7; ifid_rs1 = 7; ifid_uses_rs1 = 0; ifid_rs2 = 2;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    tick();
    n_cmp++; if (stall_count !== 4'd2) begin $display("FAIL lu_count2 got=%0d exp=2", stall_count); n_fail++; end
    clear_inputs();
  endtask

  task automatic test_branch();
    tick();
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_uses_rs2 = 1; ex_branch_taken = 1;
    #1;
    n_cmp++; if (ctl !== REDIR) begin $display("FAIL br_ctl got=%b exp=%b", ctl, REDIR); n_fail++; end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL br_after_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    n_cmp++; if (stall_count !== 4'd2) begin $display("FAIL br_count got=%0d exp=2", stall_count); n_fail++; end
  endtask

  task automatic test_stall_count();
    logic [CNT_W-1:0] exp_cnt;
    tick();
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_uses_rs2 = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (2 + i > 15) ? 4'd15 : CNT_W'(2 + i);
      n_cmp++;
      if (stall_count !== exp_cnt) begin
        $display("FAIL sc_step%0d got=%0d exp=%0d", i, stall_count, exp_cnt); n_fail++;
      end
    end
    clear_inputs();
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL sc_after_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
  endtask

  task automatic test_async_reset_pend();
    tick();
    dmem_busy = 1; ex_branch_taken = 1;
    #1;
    n_cmp++; if (ctl !== FRZ) begin $display("FAIL ar_frz_ctl got=%b exp=%b", ctl, FRZ); n_fail++; end
    tick();
    ex_branch_taken = 0;
    #1;
    n_cmp++; if (ctl !== FRZ) begin $display("FAIL ar_pend_ctl got=%b exp=%b", ctl, FRZ); n_fail++; end
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (ctl !== ZERO) begin $display("FAIL ar_inreset_ctl got=%b exp=%b", ctl, ZERO); n_fail++; end
    n_cmp++; if (stall_count !== 4'd0) begin $display("FAIL ar_count got=%0d exp=0", stall_count); n_fail++; end
    dmem_busy = 0;
    tick();
    rst_n = 1;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL ar_release_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    tick();
    n_cmp++; if (ctl !== NORM) begin $display("FAIL ar_next_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
  endtask

  task automatic test_deferred();
    tick();
    dmem_busy = 1;
    #1;
    n_cmp++; if (ctl !== FRZ) begin $display("FAIL df_c1_ctl got=%b exp=%b", ctl, FRZ); n_fail++; end
    tick();
    ex_branch_taken = 1;
    #1;
    n_cmp++; if (ctl !== FRZ) begin $display("FAIL df_c2_ctl got=%b exp=%b", ctl, FRZ); n_fail++; end
    tick();
    ex_branch_taken = 0;
    #1;
    n_cmp++; if (ctl !== FRZ) begin $display("FAIL df_c3_ctl got=%b exp=%b", ctl, FRZ); n_fail++; end
    tick();
    dmem_busy = 0;
    #1;
    n_cmp++; if (ctl !== REDIR) begin $display("FAIL df_c4_ctl got=%b exp=%b", ctl, REDIR); n_fail++; end
    n_cmp++; if (stall_count !== 4'd3) begin $display("FAIL df_count got=%0d exp=3", stall_count); n_fail++; end
    tick();
    n_cmp++; if (ctl !== NORM) begin $display("FAIL df_c5_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    // branch at entry of freeze, second branch in the release cycle: one redirect only
    dmem_busy = 1; ex_branch_taken = 1;
    tick();
    dmem_busy = 0;
    #1;
    n_cmp++; if (ctl !== REDIR) begin $display("FAIL mg_release_ctl got=%b exp=%b", ctl, REDIR); n_fail++; end
    tick();
    ex_branch_taken = 0;
    #1;
    n_cmp++; if (ctl !== NORM) begin $display("FAIL mg_after_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    n_cmp++; if (stall_count !== 4'd4) begin $display("FAIL mg_count got=%0d exp=4", stall_count); n_fail++; end
  endtask

  task automatic test_timeout();
    tick();
    dmem_busy = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++; if (mem_timeout !== 1'b0) begin $display("FAIL to7_cyc%0d got=%b exp=0", i, mem_timeout); n_fail++; end
    end
    dmem_busy = 0;
    tick();
    n_cmp++; if (mem_timeout !== 1'b0) begin $display("FAIL to7_after got=%b exp=0", mem_timeout); n_fail++; end
    dmem_busy = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (mem_timeout !== (i == 8)) begin
        $display("FAIL to8_cyc%0d got=%b exp=%b", i, mem_timeout, (i == 8)); n_fail++;
      end
    end
    dmem_busy = 0;
    tick(); tick();
    n_cmp++; if (mem_timeout !== 1'b1) begin $display("FAIL to_sticky got=%b exp=1", mem_timeout); n_fail++; end
    n_cmp++; if (ctl !== NORM) begin $display("FAIL to_after_ctl got=%b exp=%b", ctl, NORM); n_fail++; end
    n_cmp++; if (stall_count !== 4'd15) begin $display("FAIL to_count got=%0d exp=15", stall_count); n_fail++; end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_stall_count();
    test_async_reset_pend();
    test_deferred();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
